// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a counter that has to reach width-1; at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fulladd_dataflow.sv
// One-bit full adder cell, dataflow style.
module fulladd_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// then one bit per clock is added LSB first through a single full-adder
// cell with the carry held in a flip-flop. The result is published
// together with a one-cycle done pulse on the WIDTH-th edge after accept.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sreg;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             carry_next;

    // The only arithmetic in the block: current LSBs plus the stored carry.
    fulladd_dataflow u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (s_bit),
        .co (carry_next)
    );

    // Control FSM, operand/sum shift registers and registered outputs.
    // NOTE: every register here uses <= so all of them update from the
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are plain flops, not a RAM, so they
            // can be cleared here; a stale partial result is discarded.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    sreg  <= {s_bit, sreg[WIDTH-1:1]};
                    carry <= carry_next;
                    if (cnt == LAST_BIT) begin
                        sum   <= {s_bit, sreg[WIDTH-1:1]};
                        cout  <= carry_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
